// File: rtl/spike_event_logger.sv
// spike_event_logger
//   Timestamps output-layer spike activity once per SNN time step. Each
//   non-empty step is pushed into a first-word-fall-through event FIFO.
//   Per-neuron saturating spike counters run alongside the FIFO.
//
// Ports
//   system_clock   single rising-edge clock
//   reset          asynchronous active-low reset
//   enable         logging enable (level)
//   step_strobe    level; its rising edge marks one time step
//   output_spikes  output-layer spikes, sampled on the step edge
//   clear          synchronous clear; overrides step, write and pop
//   rd_en          pop request for the FIFO head
//   rd_data        {spikes, timestamp} at the FIFO head; valid when rd_valid=1
//   rd_valid       FIFO not empty
//   fifo_count     current FIFO occupancy
//   overflow       sticky: at least one event was dropped
//   dropped_count  saturating count of dropped events
//   spike_counts   per-neuron counters; neuron i at [i*CNT_WIDTH +: CNT_WIDTH]
//   timestamp      current step counter
module spike_event_logger #(
  parameter int NUM_OUT    = 2,
  parameter int TS_WIDTH   = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          system_clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          step_strobe,
  input  logic [NUM_OUT-1:0]            output_spikes,
  input  logic                          clear,
  input  logic                          rd_en,
  output logic [NUM_OUT+TS_WIDTH-1:0]   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          dropped_count,
  output logic [NUM_OUT*CNT_WIDTH-1:0]  spike_counts,
  output logic [TS_WIDTH-1:0]           timestamp
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = NUM_OUT + TS_WIDTH;
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  logic [EW-1:0]                       r_mem [FIFO_DEPTH];
  logic [AW-1:0]                       r_wr_ptr;
  logic [AW-1:0]                       r_rd_ptr;
  logic [AW:0]                         r_count;
  logic [TS_WIDTH-1:0]                 r_ts;
  logic [NUM_OUT-1:0][CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]                r_drop_cnt;
  logic                                r_overflow;
  logic                                r_strobe_d;

  logic w_step;
  logic w_wr_req;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  // clear suppresses every state-changing event in its cycle
  assign w_step   = step_strobe & ~r_strobe_d & enable & ~clear;
  assign w_wr_req = w_step & (|output_spikes);
  assign w_full   = (r_count == FULL_C);
  assign w_pop    = rd_en & rd_valid & ~clear;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr     = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  assign rd_data       = r_mem[r_rd_ptr];
  assign rd_valid      = (r_count != '0);
  assign fifo_count    = r_count;
  assign overflow      = r_overflow;
  assign dropped_count = r_drop_cnt;
  assign spike_counts  = r_cnt;
  assign timestamp     = r_ts;

  // strobe history tracks the input every cycle, even under clear or disable
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) r_strobe_d <= 1'b0;
    else        r_strobe_d <= step_strobe;
  end

  always_ff @(posedge system_clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= {output_spikes, r_ts};
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_ts <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_ts <= r_ts + TS_WIDTH'(1);
      for (int i = 0; i < NUM_OUT; i++) begin
        if (output_spikes[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic [1:0]  spikes = 2'b00;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [7:0]  dropped_count;
  logic [15:0] spike_counts;
  logic [13:0] timestamp;

  // narrow-timestamp instance used only for the wrap check
  logic        en4 = 1'b0;
  logic        strobe4 = 1'b0;
  logic [1:0]  spk4 = 2'b00;
  logic        clr4 = 1'b0;
  logic        rd4 = 1'b0;
  logic [5:0]  rd_data4;
  logic        rd_valid4;
  logic [4:0]  fifo_count4;
  logic        overflow4;
  logic [7:0]  dropped4;
  logic [15:0] counts4;
  logic [3:0]  ts4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spike_event_logger u_dut (
    .system_clock(clk), .reset(reset), .enable(enable), .step_strobe(strobe),
    .output_spikes(spikes), .clear(clear), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .overflow(overflow),
    .dropped_count(dropped_count), .spike_counts(spike_counts), .timestamp(timestamp)
  );

  spike_event_logger #(.TS_WIDTH(4)) u_dut4 (
    .system_clock(clk), .reset(reset), .enable(en4), .step_strobe(strobe4),
    .output_spikes(spk4), .clear(clr4), .rd_en(rd4), .rd_data(rd_data4),
    .rd_valid(rd_valid4), .fifo_count(fifo_count4), .overflow(overflow4),
    .dropped_count(dropped4), .spike_counts(counts4), .timestamp(ts4)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an event queue plus plain counters.
  logic [15:0] m_q[$];
  logic [13:0] m_ts;
  int          m_cnt[2];
  bit          m_ovf;
  int          m_drop;
  bit          m_prev;

  always @(posedge clk or negedge reset) begin
    bit step;
    if (!reset) begin
      m_q.delete(); m_ts = '0; m_cnt[0] = 0; m_cnt[1] = 0;
      m_ovf = 0; m_drop = 0; m_prev = 0;
    end else begin
      step = strobe && !m_prev && enable;
      if (clear) begin
        m_q.delete(); m_ts = '0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_ovf = 0; m_drop = 0;
      end else begin
        if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
        if (step) begin
          if (spikes != 2'b00) begin
            if (m_q.size() < 16) m_q.push_back({spikes, m_ts});
            else begin
              m_ovf = 1;
              if (m_drop < 255) m_drop++;
            end
          end
          for (int i = 0; i < 2; i++)
            if (spikes[i] && m_cnt[i] < 255) m_cnt[i]++;
          m_ts = m_ts + 14'd1;
        end
      end
      m_prev = strobe;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rd_valid", rd_valid, m_q.size() != 0);
      chk("fifo_count", fifo_count, m_q.size());
      if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
      chk("overflow", overflow, m_ovf);
      chk("dropped_count", dropped_count, m_drop);
      chk("timestamp", timestamp, m_ts);
      for (int i = 0; i < 2; i++) chk("spike_counts", spike_counts[i*8 +: 8], m_cnt[i]);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input logic [1:0] s);
    spikes = s; strobe = 1'b1; cyc(); strobe = 1'b0; cyc();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    chk(name, rd_data, exp);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  initial begin
    logic [5:0] e4;
    cyc(2);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset timestamp", timestamp, 0);
    reset = 1'b1;
    enable = 1'b1;
    cyc();

    // three steps of neuron 0
    repeat (3) step(2'b01);
    chk("t1 fifo_count", fifo_count, 3);
    chk("t1 timestamp", timestamp, 3);
    chk("t1 cnt0", spike_counts[7:0], 3);
    chk("t1 cnt1", spike_counts[15:8], 0);
    pop_expect("t1 ev0", {2'b01, 14'd0});
    pop_expect("t1 ev1", {2'b01, 14'd1});
    pop_expect("t1 ev2", {2'b01, 14'd2});
    chk("t1 empty", rd_valid, 0);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("pop empty ignored", fifo_count, 0);

    // held strobe yields a single step
    pulse_clear();
    spikes = 2'b11; strobe = 1'b1; cyc(10); strobe = 1'b0; cyc();
    chk("t2 fifo_count", fifo_count, 1);
    chk("t2 cnt0", spike_counts[7:0], 1);
    chk("t2 cnt1", spike_counts[15:8], 1);
    pop_expect("t2 ev", {2'b11, 14'd0});

    // empty steps only advance the timestamp
    pulse_clear();
    repeat (5) step(2'b00);
    step(2'b10);
    chk("t3 fifo_count", fifo_count, 1);
    chk("t3 timestamp", timestamp, 6);
    pop_expect("t3 ev", {2'b10, 14'd5});

    // overflow
    pulse_clear();
    repeat (18) step(2'b01);
    chk("t4 fifo_count", fifo_count, 16);
    chk("t4 overflow", overflow, 1);
    chk("t4 dropped", dropped_count, 2);
    chk("t4 head", rd_data, {2'b01, 14'd0});
    chk("t4 cnt0", spike_counts[7:0], 18);

    // pop coincident with step while full
    spikes = 2'b01; rd_en = 1'b1; strobe = 1'b1; cyc();
    rd_en = 1'b0; strobe = 1'b0; cyc();
    chk("t5 fifo_count", fifo_count, 16);
    chk("t5 head", rd_data, {2'b01, 14'd1});
    rd_en = 1'b1; cyc(15); rd_en = 1'b0;
    pop_expect("t5 tail", {2'b01, 14'd18});
    chk("t5 drained", rd_valid, 0);
    chk("t5 sticky overflow", overflow, 1);

    // write and pop together with a single entry
    pulse_clear();
    step(2'b01);
    spikes = 2'b10; rd_en = 1'b1; strobe = 1'b1; cyc();
    rd_en = 1'b0; strobe = 1'b0; cyc();
    chk("cnt1 simul count", fifo_count, 1);
    chk("cnt1 simul head", rd_data, {2'b10, 14'd1});

    // disable freezes stepping, pop still works
    enable = 1'b0;
    step(2'b11);
    chk("dis timestamp", timestamp, 2);
    chk("dis fifo_count", fifo_count, 1);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("dis pop", fifo_count, 0);
    enable = 1'b1;

    // clear coincident with a step edge
    step(2'b01); step(2'b11);
    spikes = 2'b11; strobe = 1'b1; clear = 1'b1; cyc();
    clear = 1'b0;
    chk("clr fifo_count", fifo_count, 0);
    chk("clr timestamp", timestamp, 0);
    chk("clr counts", spike_counts, 0);
    cyc();
    chk("clr held strobe", timestamp, 0);
    strobe = 1'b0; cyc();

    // counter saturation
    repeat (300) step(2'b01);
    chk("sat cnt0", spike_counts[7:0], 255);
    chk("sat dropped", dropped_count, 255);
    chk("sat fifo_count", fifo_count, 16);

    // timestamp wrap on the 4-bit instance
    en4 = 1'b1; spk4 = 2'b01;
    for (int i = 0; i < 17; i++) begin
      strobe4 = 1'b1; cyc(); strobe4 = 1'b0; cyc();
      e4 = {2'b01, 4'(i)};
      chk("wrap valid", rd_valid4, 1);
      chk("wrap ev", rd_data4, e4);
      rd4 = 1'b1; cyc(); rd4 = 1'b0;
    end
    chk("wrap ts", ts4, 1);

    // asynchronous reset mid-operation
    step(2'b00);
    #2 reset = 1'b0;
    #1;
    chk("arst rd_valid", rd_valid, 0);
    chk("arst fifo_count", fifo_count, 0);
    chk("arst overflow", overflow, 0);
    chk("arst dropped", dropped_count, 0);
    chk("arst counts", spike_counts, 0);
    chk("arst timestamp", timestamp, 0);
    cyc();
    reset = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
- Sits directly downstream of the spiking network top level and consumes its 2-bit output spike vector.
- On every SNN time step it timestamps output-layer activity, pushes non-empty events into a first-word-fall-through FIFO and keeps per-neuron saturating spike counters.
- The host drains the FIFO with a simple valid/pop handshake, so output spikes are not lost between SPI polls.

Parameters:
- NUM_OUT, 2, number of output neurons (width of output_spikes).
- TS_WIDTH, 14, timestamp counter width; event word width is NUM_OUT+TS_WIDTH.
- FIFO_DEPTH, 16, event FIFO entries; must be a power of two.
- CNT_WIDTH, 8, width of each per-neuron spike counter.

Ports:
- system_clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  logging enable (level).
- step_strobe  in  1  synchronous level; its rising edge marks one SNN time step (driven from the synchronized input_ready).
- output_spikes  in  NUM_OUT  output-layer spikes, sampled on the step edge.
- clear  in  1  synchronous clear pulse.
- rd_en  in  1  pop request.
- rd_data  out  NUM_OUT+TS_WIDTH  {spikes, timestamp} of the FIFO head.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: an event was dropped.
- dropped_count  out  CNT_WIDTH  number of dropped events (saturating).
- spike_counts  out  NUM_OUT*CNT_WIDTH  per-neuron counters; neuron i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- timestamp  out  TS_WIDTH  current step counter.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, fifo_count, timestamp, spike_counts, dropped_count and overflow go to 0.
  - strobe_d goes to 0; rd_valid=0.
  - rd_data is unspecified while rd_valid=0 (verify only when rd_valid=1).
- Step detect: step = step_strobe & ~strobe_d & enable.
  - strobe_d is registered from step_strobe every cycle regardless of enable.
  - A step_strobe held high produces exactly one step.
- On step:
  - Event word = {output_spikes, timestamp}, using the pre-increment timestamp value.
  - timestamp <= timestamp+1 and wraps to 0 after 2^TS_WIDTH-1.
  - Each spike_counts[i] increments if output_spikes[i]=1, saturating at 2^CNT_WIDTH-1.
  - A write is requested only if output_spikes != 0. An all-zero step advances the timestamp only.
- FIFO (FWFT):
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = (fifo_count != 0).
  - A pop occurs on rd_en & rd_valid; rd_en while empty is ignored with no state change.
  - Write latency: the event is visible on rd_data/rd_valid the cycle after the step edge is detected.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop in the same cycle: both happen and fifo_count is unchanged. This holds when full and when count=1.
  - Write while full with no pop: the event is dropped, overflow <= 1, and dropped_count increments (saturating). Timestamp and spike_counts still update.
- clear (synchronous):
  - Highest priority over step, write and pop.
  - Sets FIFO empty and zeroes timestamp, spike_counts, dropped_count and overflow.
  - An edge coincident with clear is discarded; strobe_d still updates.
- enable=0:
  - No steps, no writes, timestamp and counters frozen.
  - Popping remains allowed.
- overflow remains 1 until reset or clear; it is not cleared by draining the FIFO.
- fifo_count always equals writes minus pops since the last clear, within 0..FIFO_DEPTH.

Test Plan:
- Reset then enable=1, output_spikes=2'b01, 3 rising edges of step_strobe -> 3 events {01,0},{01,1},{01,2}; spike_counts[0]=3, spike_counts[1]=0; fifo_count=3; timestamp=3.
- step_strobe held high for 10 cycles with output_spikes=2'b11 -> exactly 1 event; both counters=1.
- 5 steps with output_spikes=0, then 1 step with 2'b10 -> single event {10,5}; timestamp=6.
- 18 steps with 2'b01 and no reads (depth 16) -> fifo_count=16, overflow=1, dropped_count=2; head={01,0}; spike_counts[0]=18.
- With FIFO full, rd_en coincident with a step -> count stays 16 and the new event is appended at the tail; next rd_data={01,1}.
- Mid-stream: clear coincident with a step edge -> everything zero next cycle and no event written. Separately, assert reset=0 mid-operation -> all outputs 0 immediately.
- Wrap: with TS_WIDTH=4, 17 steps -> event timestamps 0..15 then 0.
